// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

    // Controller states, 4-bit binary encoding
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTYPEEX = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BEQEX   = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JEX     = 4'd11
    } state_t;

    // How the ALU operation is chosen in a given state
    typedef enum logic [1:0] {
        ALU_MODE_ADD   = 2'd0,
        ALU_MODE_SUB   = 2'd1,
        ALU_MODE_FUNCT = 2'd2
    } alu_mode_t;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instruction bits [5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes: bit 2 inverts B with carry-in, bits [1:0] pick the result
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the state-derived ALU mode and FUNCT to the 4-bit ALU operation.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_mode_t  alu_mode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_vld
);

    logic [3:0] funct_op;

    // Translate the R-type function field; unsupported codes fall back to ADD
    always_comb begin
        funct_op  = ALU_ADD;
        funct_vld = 1'b1;
        case (funct)
            FN_ADD:  funct_op = ALU_ADD;
            FN_SUB:  funct_op = ALU_SUB;
            FN_AND:  funct_op = ALU_AND;
            FN_OR:   funct_op = ALU_OR;
            FN_SLT:  funct_op = ALU_SLT;
            default: begin
                funct_op  = ALU_ADD;
                funct_vld = 1'b0;
            end
        endcase
    end

    // Select the final operation from the mode requested by the controller
    always_comb begin
        alu_op = ALU_ADD;
        case (alu_mode)
            ALU_MODE_ADD:   alu_op = ALU_ADD;
            ALU_MODE_SUB:   alu_op = ALU_SUB;
            ALU_MODE_FUNCT: alu_op = funct_op;
            default:        alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle Moore controller sequencing fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction (lw 5, sw/R/addi 4, beq/j 3).
// Backpressure: none; advances one state per clock, reset abandons work.
module mc_control
    import mc_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    output logic       PCEN,
    output logic       IORD,
    output logic       MEMWRITE,
    output logic       IRWRITE,
    output logic       REGDST,
    output logic       MEMTOREG,
    output logic       REGWRITE,
    output logic       ALUSRCA,
    output logic [1:0] ALUSRCB,
    output logic [1:0] PCSRC,
    output logic [3:0] ALU_OP,
    output logic       ILLEGAL
);

    state_t    state_q;
    state_t    state_d;
    alu_mode_t alu_mode;
    logic      funct_vld;
    logic      pcwrite;
    logic      branch;
    logic      opcode_vld;

    alu_decoder u_alu_decoder (
        .alu_mode  (alu_mode),
        .funct     (FUNCT),
        .alu_op    (ALU_OP),
        .funct_vld (funct_vld)
    );

    // State register; reset parks the machine in FETCH immediately
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is legal if it is one of the six supported instructions
    always_comb begin
        opcode_vld = 1'b0;
        case (OPCODE)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: opcode_vld = 1'b1;
            default:                                       opcode_vld = 1'b0;
        endcase
    end

    // Next-state logic; OPCODE/FUNCT are only looked at in DECODE and MEMADR
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = funct_vld ? ST_RTYPEEX : ST_FETCH;
                    OP_BEQ:       state_d = ST_BEQEX;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JEX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (OPCODE == OP_LW) begin
                    state_d = ST_MEMRD;
                end else if (OPCODE == OP_SW) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMRD:   state_d = ST_MEMWB;
            ST_RTYPEEX: state_d = ST_RTYPEWB;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; enables are additionally held low while in reset
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        IORD     = 1'b0;
        MEMWRITE = 1'b0;
        IRWRITE  = 1'b0;
        REGDST   = 1'b0;
        MEMTOREG = 1'b0;
        REGWRITE = 1'b0;
        ALUSRCA  = 1'b0;
        ALUSRCB  = 2'b00;
        PCSRC    = 2'b00;
        alu_mode = ALU_MODE_ADD;
        ILLEGAL  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                IRWRITE = 1'b1;
                pcwrite = 1'b1;
                ALUSRCB = 2'b01;
            end
            ST_DECODE: begin
                ALUSRCB = 2'b11;
                // Unsupported opcode, or R-type with unsupported funct
                ILLEGAL = !opcode_vld || ((OPCODE == OP_RTYPE) && !funct_vld);
            end
            ST_MEMADR: begin
                ALUSRCA = 1'b1;
                ALUSRCB = 2'b10;
            end
            ST_MEMRD: begin
                IORD = 1'b1;
            end
            ST_MEMWB: begin
                REGWRITE = 1'b1;
                MEMTOREG = 1'b1;
            end
            ST_MEMWR: begin
                IORD     = 1'b1;
                MEMWRITE = 1'b1;
            end
            ST_RTYPEEX: begin
                ALUSRCA  = 1'b1;
                alu_mode = ALU_MODE_FUNCT;
            end
            ST_RTYPEWB: begin
                REGWRITE = 1'b1;
                REGDST   = 1'b1;
            end
            ST_BEQEX: begin
                ALUSRCA  = 1'b1;
                alu_mode = ALU_MODE_SUB;
                branch   = 1'b1;
                PCSRC    = 2'b01;
            end
            ST_ADDIEX: begin
                ALUSRCA = 1'b1;
                ALUSRCB = 2'b10;
            end
            ST_ADDIWB: begin
                REGWRITE = 1'b1;
            end
            ST_JEX: begin
                pcwrite = 1'b1;
                PCSRC   = 2'b10;
            end
            default: begin
                pcwrite = 1'b0;
            end
        endcase
        if (!RST_N) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            IRWRITE  = 1'b0;
            MEMWRITE = 1'b0;
            REGWRITE = 1'b0;
            ILLEGAL  = 1'b0;
        end
    end

    assign PCEN = pcwrite | (branch & ZERO);

endmodule
